// File: rtl/fft_twiddle_seq.sv
`default_nettype none
// ============================================================================
// fft_twiddle_seq : radix-2 DIT twiddle ROM sequencer with valid/ready output
// Rev 1.0
// ============================================================================
module fft_twiddle_seq #(
    parameter int LOG2N       = 5,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 16,
    parameter int ADDR_OFFSET = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_re_data_i,
    input  logic [DATA_W-1:0] rom_im_data_i,
    output logic              tw_valid_o,
    input  logic              tw_ready_i,
    output logic [DATA_W-1:0] tw_re_o,
    output logic [DATA_W-1:0] tw_im_o,
    output logic [2:0]        tw_stage_o,
    output logic [LOG2N-2:0]  tw_bfly_o,
    output logic              tw_last_o
);

    localparam int            BW         = LOG2N - 1;
    localparam logic [2:0]    LAST_STAGE = 3'(LOG2N - 1);
    localparam logic [2:0]    STAGE_ONE  = 3'd1;
    localparam logic [BW-1:0] LAST_BFLY  = '1;
    localparam logic [BW-1:0] BFLY_ONE   = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        iss_stage_q, iss_stage_d;
    logic [BW-1:0]     iss_bfly_q, iss_bfly_d;
    logic              addr_vld_q, addr_vld_d;
    logic [2:0]        out_stage_q, out_stage_d;
    logic [BW-1:0]     out_bfly_q, out_bfly_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              data_vld_q, data_vld_d;

    logic              adv;
    logic [ADDR_W-1:0] iss_addr;

    // k(s,b) = (b mod 2^s) << (LOG2N-1-s), then offset modulo 2^ADDR_W
    function automatic logic [ADDR_W-1:0] tw_addr(input logic [2:0] s, input logic [BW-1:0] b);
        logic [BW-1:0] mask;
        logic [BW-1:0] k;
        mask = ~({BW{1'b1}} << s);
        k    = (b & mask) << (3'(BW) - s);
        return ADDR_W'(ADDR_OFFSET) + ADDR_W'(k);
    endfunction

    assign adv        = !data_vld_q || tw_ready_i;
    assign iss_addr   = tw_addr(iss_stage_q, iss_bfly_q);
    // A stall re-reads the displayed entry so the registered ROM output holds.
    assign rom_addr_o = adv ? iss_addr : out_addr_q;

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign tw_valid_o = data_vld_q;
    assign tw_re_o    = rom_re_data_i;
    assign tw_im_o    = rom_im_data_i;
    assign tw_stage_o = out_stage_q;
    assign tw_bfly_o  = out_bfly_q;
    assign tw_last_o  = data_vld_q && (out_stage_q == LAST_STAGE) && (out_bfly_q == LAST_BFLY);

    always_comb begin
        state_d     = state_q;
        iss_stage_d = iss_stage_q;
        iss_bfly_d  = iss_bfly_q;
        addr_vld_d  = addr_vld_q;
        out_stage_d = out_stage_q;
        out_bfly_d  = out_bfly_q;
        out_addr_d  = out_addr_q;
        data_vld_d  = data_vld_q;

        if (adv) begin
            out_stage_d = iss_stage_q;
            out_bfly_d  = iss_bfly_q;
            out_addr_d  = iss_addr;
            data_vld_d  = addr_vld_q;
            if (addr_vld_q) begin
                if (iss_bfly_q == LAST_BFLY) begin
                    iss_bfly_d = '0;
                    if (iss_stage_q == LAST_STAGE) begin
                        addr_vld_d = 1'b0;
                    end else begin
                        iss_stage_d = iss_stage_q + STAGE_ONE;
                    end
                end else begin
                    iss_bfly_d = iss_bfly_q + BFLY_ONE;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_RUN;
                    iss_stage_d = '0;
                    iss_bfly_d  = '0;
                    addr_vld_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (adv && addr_vld_q && (iss_stage_q == LAST_STAGE) && (iss_bfly_q == LAST_BFLY)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tw_ready_i && tw_last_o) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort_i) begin
            state_d    = S_IDLE;
            addr_vld_d = 1'b0;
            data_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            iss_stage_q <= '0;
            iss_bfly_q  <= '0;
            addr_vld_q  <= 1'b0;
            out_stage_q <= '0;
            out_bfly_q  <= '0;
            out_addr_q  <= '0;
            data_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            iss_stage_q <= iss_stage_d;
            iss_bfly_q  <= iss_bfly_d;
            addr_vld_q  <= addr_vld_d;
            out_stage_q <= out_stage_d;
            out_bfly_q  <= out_bfly_d;
            out_addr_q  <= out_addr_d;
            data_vld_q  <= data_vld_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_twiddle_seq.sv
`default_nettype none
// ============================================================================
// tb_fft_twiddle_seq : directed bench, two instances (offset 0 and offset 4)
// Rev 1.0
// ============================================================================
module tb_fft_twiddle_seq;

    localparam int NPAIR = 80;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, ready;
    logic        busy [2], done [2], valid [2], last [2];
    logic [4:0]  rom_addr [2];
    logic [15:0] rre [2], rim [2], twre [2], twim [2];
    logic [2:0]  stg [2];
    logic [3:0]  bfl [2];
    logic [15:0] re_rom [32], im_rom [32];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    fft_twiddle_seq #(.LOG2N(5), .ADDR_W(5), .DATA_W(16), .ADDR_OFFSET(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .busy_o(busy[0]), .done_o(done[0]), .rom_addr_o(rom_addr[0]),
        .rom_re_data_i(rre[0]), .rom_im_data_i(rim[0]),
        .tw_valid_o(valid[0]), .tw_ready_i(ready),
        .tw_re_o(twre[0]), .tw_im_o(twim[0]), .tw_stage_o(stg[0]),
        .tw_bfly_o(bfl[0]), .tw_last_o(last[0]));

    fft_twiddle_seq #(.LOG2N(5), .ADDR_W(5), .DATA_W(16), .ADDR_OFFSET(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .busy_o(busy[1]), .done_o(done[1]), .rom_addr_o(rom_addr[1]),
        .rom_re_data_i(rre[1]), .rom_im_data_i(rim[1]),
        .tw_valid_o(valid[1]), .tw_ready_i(ready),
        .tw_re_o(twre[1]), .tw_im_o(twim[1]), .tw_stage_o(stg[1]),
        .tw_bfly_o(bfl[1]), .tw_last_o(last[1]));

    // Synchronous ROMs, one-cycle read latency, no enable
    always @(posedge clk) begin
        rre[0] <= re_rom[rom_addr[0]];
        rim[0] <= im_rom[rom_addr[0]];
        rre[1] <= re_rom[rom_addr[1]];
        rim[1] <= im_rom[rom_addr[1]];
    end

    function automatic int exp_addr(input int n, input int off);
        int s, b, k;
        s = n / 16;
        b = n % 16;
        k = (b % (1 << s)) * (1 << (4 - s));
        return (k + off) % 32;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    task automatic check_pair(input int i, input int n);
        int a;
        a = exp_addr(n, 4 * i);
        chk("tw_re", i, 32'(twre[i]), 32'(re_rom[a]));
        chk("tw_im", i, 32'(twim[i]), 32'(im_rom[a]));
        chk("tw_stage", i, 32'(stg[i]), n / 16);
        chk("tw_bfly", i, 32'(bfl[i]), n % 16);
        chk("tw_last", i, 32'(last[i]), 32'(n == NPAIR - 1));
    endtask

    // One full sweep from IDLE; entered and left at a negedge (+1)
    task automatic sweep(input bit rnd, input int stall_at, input int restart_at);
        int n, cyc, stalls;
        bit rdy;
        n = 0; cyc = 0; stalls = 0;
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (n < NPAIR && cyc < 3000) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n == stall_at && valid[0] && stalls < 3) begin
                rdy = 1'b0;
                stalls++;
            end
            ready = rdy;
            start = (n == restart_at);
            #1;
            for (int i = 0; i < 2; i++) begin
                chk("done_early", i, 32'(done[i]), 0);
                chk("busy_run", i, 32'(busy[i]), 1);
                if (!rnd) chk("valid_seq", i, 32'(valid[i]), 32'(cyc != 0));
                if (valid[i]) begin
                    check_pair(i, n);
                    if (!ready) chk("replay_addr", i, 32'(rom_addr[i]), exp_addr(n, 4 * i));
                end
            end
            if (valid[0] && ready) n++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        chk("pair_count", 0, n, NPAIR);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("done_pulse", i, 32'(done[i]), 1);
            chk("busy_at_done", i, 32'(busy[i]), 1);
            chk("valid_after_last", i, 32'(valid[i]), 0);
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("done_cleared", i, 32'(done[i]), 0);
            chk("busy_cleared", i, 32'(busy[i]), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
        for (int a = 0; a < 32; a++) begin
            re_rom[a] = 16'h5A00 ^ 16'(a * 16'h0123);
            im_rom[a] = 16'hC3C3 + 16'(a * 16'h0401);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, 32'(busy[i]), 0);
            chk("rst_done", i, 32'(done[i]), 0);
            chk("rst_valid", i, 32'(valid[i]), 0);
            chk("rst_last", i, 32'(last[i]), 0);
            chk("rst_stage", i, 32'(stg[i]), 0);
            chk("rst_bfly", i, 32'(bfl[i]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sweep(1'b0, -1, -1);   // nominal
        sweep(1'b0, 5, -1);    // 3-cycle stall on pair 6
        sweep(1'b1, -1, -1);   // random backpressure
        sweep(1'b0, -1, 20);   // start while running is ignored

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) chk("start_abort_busy", i, 32'(busy[i]), 0);
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk("start_abort_valid", i, 32'(valid[i]), 0);

        // abort while pair 40 is shown and not accepted
        start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < 39 && cyc < 200) begin
            #1;
            if (valid[0]) n++;
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach", 0, n, 39);
        ready = 1'b0; abort = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("abort_pre_valid", i, 32'(valid[i]), 1);
            chk("abort_pre_stage", i, 32'(stg[i]), 2);
            chk("abort_pre_bfly", i, 32'(bfl[i]), 7);
        end
        @(negedge clk);
        abort = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("abort_valid", i, 32'(valid[i]), 0);
            chk("abort_busy", i, 32'(busy[i]), 0);
            chk("abort_done", i, 32'(done[i]), 0);
            chk("abort_last", i, 32'(last[i]), 0);
        end
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk("abort_no_done", i, 32'(done[i]), 0);
        sweep(1'b0, -1, -1);

        // asynchronous reset in the middle of a sweep
        start = 1'b1; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk("prereset_valid", i, 32'(valid[i]), 1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_valid", i, 32'(valid[i]), 0);
            chk("arst_busy", i, 32'(busy[i]), 0);
            chk("arst_stage", i, 32'(stg[i]), 0);
            chk("arst_bfly", i, 32'(bfl[i]), 0);
            chk("arst_last", i, 32'(last[i]), 0);
            chk("arst_done", i, 32'(done[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sweep(1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
